// File: rtl/move_seq_pkg.sv
// move_sequencer shared types: per-axis profile word layout and FSM states.
// Abort support is compiled in with MOVE_SEQ_ABORT_EN.
package move_seq_pkg;

  localparam int NUM_PARAMS = 5;
  localparam int PARAM_W    = 32;
  localparam int AXIS_W     = NUM_PARAMS * PARAM_W;

  localparam int P_N     = 0;
  localparam int P_NN    = 1;
  localparam int P_T0    = 2;
  localparam int P_TNA   = 3;
  localparam int P_DELTA = 4;

  // first member lands in the MSBs, so n ends up in the low word
  typedef struct packed {
    logic [PARAM_W-1:0] delta;
    logic [PARAM_W-1:0] tna;
    logic [PARAM_W-1:0] t0;
    logic [PARAM_W-1:0] nn;
    logic [PARAM_W-1:0] n;
  } axis_params_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    GAP
  } state_t;

endpackage

// File: rtl/move_cmd_fifo.sv
// Move command queue: synchronous FIFO with wrap-bit pointers and flush.
// Used by move_sequencer (MOVE_SEQ_ABORT_EN drives flush).
module move_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 640
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/move_sequencer.sv
// Move command scheduler driving all axis step generators in lockstep.
// Define MOVE_SEQ_ABORT_EN to add the synchronous abort/flush input.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int NUM_AXES   = 4,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [NUM_AXES*AXIS_W-1:0]     cmd_data,
  output logic [NUM_AXES*AXIS_W-1:0]     axis_params,
  output logic [NUM_AXES-1:0]            axis_start,
  input  logic [NUM_AXES-1:0]            axis_finish,
  output logic                           move_done,
  output logic                           busy,
  output logic [$clog2(DEPTH):0]         level,
  output logic [31:0]                    moves_completed
`ifdef MOVE_SEQ_ABORT_EN
  ,
  input  logic                           abort
`endif
);

  localparam int CMD_W = NUM_AXES * AXIS_W;
  localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW    = $clog2(GAP_N + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_N - 1);

  state_t           state;
  state_t           state_nx;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_nx;
  logic             pop;
  logic             push;
  logic             done;
  logic             abort_hit;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head;

`ifdef MOVE_SEQ_ABORT_EN
  // an abort with nothing running and nothing queued is a no-op
  assign abort_hit = abort && !(state == IDLE && fifo_empty);
`else
  assign abort_hit = 1'b0;
`endif

  assign push      = cmd_valid && !fifo_full && !abort_hit;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  move_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort_hit),
    .wdata (cmd_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    pop      = 1'b0;
    done     = 1'b0;
    if (abort_hit) begin
      state_nx = GAP;
      gap_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state_nx = LOAD;
            pop      = 1'b1;
          end
        end
        LOAD: state_nx = RUN;
        RUN: begin
          if (&axis_finish) begin
            state_nx = GAP;
            gap_nx   = '0;
            done     = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (!fifo_empty) begin
              state_nx = LOAD;
              pop      = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            gap_nx = gap_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      axis_params     <= '0;
      axis_start      <= '0;
      move_done       <= 1'b0;
      moves_completed <= '0;
    end else begin
      state      <= state_nx;
      gap_cnt    <= gap_nx;
      axis_start <= {NUM_AXES{state_nx == RUN}};
      move_done  <= done;
      if (pop)  axis_params     <= head;
      if (done) moves_completed <= moves_completed + 32'd1;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with simple per-axis generator models.
// Abort scenario is included when MOVE_SEQ_ABORT_EN is defined.
module tb_move_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [639:0] cmd_data;
  logic [639:0] axis_params;
  logic [3:0]   axis_start;
  logic [3:0]   axis_finish;
  logic         move_done;
  logic         busy;
  logic [3:0]   level;
  logic [31:0]  moves_completed;
`ifdef MOVE_SEQ_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  gcnt [4];
  logic [3:0]   gfin;
  logic         gen_en;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_data        (cmd_data),
    .axis_params     (axis_params),
    .axis_start      (axis_start),
    .axis_finish     (axis_finish),
    .move_done       (move_done),
    .busy            (busy),
    .level           (level),
    .moves_completed (moves_completed)
`ifdef MOVE_SEQ_ABORT_EN
    ,
    .abort           (abort)
`endif
  );

  // generator model: finish rises N cycles after start (N=0 acts as 1)
  // and holds until start drops
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 4; a++) gcnt[a] <= '0;
      gfin <= '0;
    end else begin
      for (int a = 0; a < 4; a++) begin
        if (!axis_start[a]) begin
          gcnt[a] <= '0;
          gfin[a] <= 1'b0;
        end else begin
          gcnt[a] <= gcnt[a] + 32'd1;
          gfin[a] <= (gcnt[a] + 32'd1) >= nlim(axis_params[a*160 +: 32]);
        end
      end
    end
  end

  assign axis_finish = gfin & {4{gen_en}};

  function automatic logic [31:0] nlim(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

  function automatic logic [639:0] mk_cmd(
    input logic [31:0] n0, input logic [31:0] n1,
    input logic [31:0] n2, input logic [31:0] n3,
    input logic [31:0] tag
  );
    logic [639:0] r;
    r = '0;
    r[0 +: 32]   = n0;
    r[160 +: 32] = n1;
    r[320 +: 32] = n2;
    r[480 +: 32] = n3;
    for (int a = 0; a < 4; a++) begin
      r[a*160+32 +: 32]  = tag;
      r[a*160+64 +: 32]  = tag + 32'd1;
      r[a*160+96 +: 32]  = tag + 32'd2;
      r[a*160+128 +: 32] = tag + 32'd3;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_one(input logic [639:0] d);
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready);
    end
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL rst_level got %0d exp 0", level);
    end
    checks++;
    if (busy !== 1'b0 || move_done !== 1'b0) begin
      errors++; $display("FAIL rst_busy_done got %b%b exp 00", busy, move_done);
    end
    checks++;
    if (axis_start !== 4'h0) begin
      errors++; $display("FAIL rst_start got %h exp 0", axis_start);
    end
    checks++;
    if (moves_completed !== 32'd0 || axis_params !== '0) begin
      errors++; $display("FAIL rst_cnt_params got %0d exp 0", moves_completed);
    end
  endtask

  task automatic test_single_move();
    logic [639:0] d;
    int n;
    d = mk_cmd(32'd10, 32'd0, 32'd0, 32'd0, 32'h100);
    push_one(d);
    checks++;
    if (level !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_queued got lvl %0d busy %b exp 1 1", level, busy);
    end
    tick();
    checks++;
    if (axis_start !== 4'h0 || level !== 4'd0) begin
      errors++; $display("FAIL single_load got start %h lvl %0d exp 0 0", axis_start, level);
    end
    checks++;
    if (axis_params !== d) begin
      errors++; $display("FAIL single_params got %h exp %h", axis_params, d);
    end
    tick();
    checks++;
    if (axis_start !== 4'hf) begin
      errors++; $display("FAIL single_start got %h exp f", axis_start);
    end
    n = 0;
    while (!move_done && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 11) begin
      errors++; $display("FAIL single_done_lat got %0d exp 11", n);
    end
    checks++;
    if (moves_completed !== 32'd1 || axis_start !== 4'h0) begin
      errors++; $display("FAIL single_count got %0d start %h exp 1 0", moves_completed, axis_start);
    end
    tick();
    checks++;
    if (move_done !== 1'b0 || axis_start !== 4'h0) begin
      errors++; $display("FAIL single_gap got done %b start %h exp 0 0", move_done, axis_start);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || axis_start !== 4'h0 || axis_params !== d) begin
      errors++; $display("FAIL single_idle got busy %b start %h exp 0 0", busy, axis_start);
    end
  endtask

  task automatic test_back_to_back();
    logic [639:0] a, b, c, prev;
    int dones, loads, gaplen;
    bit ingap;
    a = mk_cmd(32'd3, 32'd3, 32'd3, 32'd3, 32'h200);
    b = mk_cmd(32'd3, 32'd3, 32'd3, 32'd3, 32'h300);
    c = mk_cmd(32'd3, 32'd3, 32'd3, 32'd3, 32'h400);
    do_reset();
    push_one(a);
    push_one(b);
    checks++;
    if (level !== 4'd1) begin
      errors++; $display("FAIL b2b_pushpop_level got %0d exp 1", level);
    end
    push_one(c);
    checks++;
    if (level !== 4'd2 || axis_start !== 4'hf) begin
      errors++; $display("FAIL b2b_level2 got %0d start %h exp 2 f", level, axis_start);
    end
    prev = axis_params;
    dones = 0; loads = 0; gaplen = 0; ingap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (axis_params !== prev) begin
        loads++;
        checks++;
        if (axis_start !== 4'h0 || level !== ((loads == 1) ? 4'd1 : 4'd0)) begin
          errors++; $display("FAIL b2b_load got start %h lvl %0d load %0d", axis_start, level, loads);
        end
        checks++;
        if (axis_params !== ((loads == 1) ? b : c)) begin
          errors++; $display("FAIL b2b_params got %h load %0d", axis_params, loads);
        end
        prev = axis_params;
      end
      if (ingap) begin
        if (axis_start !== 4'h0) begin
          checks++;
          if (gaplen !== 3 || axis_start !== 4'hf) begin
            errors++; $display("FAIL b2b_gap got %0d start %h exp 3 f", gaplen, axis_start);
          end
          ingap = 1'b0;
        end else begin
          gaplen++;
        end
      end
      if (move_done) begin
        dones++;
        ingap = 1'b1;
        gaplen = 1;
        checks++;
        if (axis_start !== 4'h0) begin
          errors++; $display("FAIL b2b_done_start got %h exp 0", axis_start);
        end
      end
    end
    checks++;
    if (dones !== 3 || loads !== 2) begin
      errors++; $display("FAIL b2b_totals got dones %0d loads %0d exp 3 2", dones, loads);
    end
    checks++;
    if (moves_completed !== 32'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got %0d busy %b exp 3 0", moves_completed, busy);
    end
  endtask

  task automatic test_full_queue();
    int n;
    do_reset();
    gen_en = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_data = mk_cmd(32'd1, 32'd1, 32'd1, 32'd1, 32'h500 + i*16);
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (level !== 4'd8 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_level got %0d ready %b exp 8 0", level, cmd_ready);
    end
    gen_en = 1'b1;
    n = 0;
    while (!move_done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (move_done !== 1'b1) begin
      errors++; $display("FAIL full_done1 timeout got %b exp 1", move_done);
    end
    tick();
    cmd_data  = mk_cmd(32'd1, 32'd1, 32'd1, 32'd1, 32'h900);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (level !== 4'd7) begin
      errors++; $display("FAIL full_pop_blocks_push got %0d exp 7", level);
    end
    n = 0;
    while (!move_done && n < 40) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (level !== 4'd7 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL full_pre_pushpop got %0d ready %b exp 7 1", level, cmd_ready);
    end
    cmd_data  = mk_cmd(32'd1, 32'd1, 32'd1, 32'd1, 32'hA00);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (level !== 4'd7) begin
      errors++; $display("FAIL full_pushpop got %0d exp 7", level);
    end
    checks++;
    if (axis_params !== mk_cmd(32'd1, 32'd1, 32'd1, 32'd1, 32'h520)) begin
      errors++; $display("FAIL full_third_params got %h", axis_params);
    end
  endtask

  task automatic test_staggered();
    logic [639:0] d;
    do_reset();
    gen_en = 1'b1;
    d = mk_cmd(32'd5, 32'd20, 32'd7, 32'd12, 32'hB00);
    push_one(d);
    tick();
    tick();
    checks++;
    if (axis_start !== 4'hf) begin
      errors++; $display("FAIL stag_start got %h exp f", axis_start);
    end
    repeat (19) tick();
    checks++;
    if (axis_finish !== 4'b1101 || axis_start !== 4'hf) begin
      errors++; $display("FAIL stag_partial got fin %b start %h exp 1101 f", axis_finish, axis_start);
    end
    tick();
    checks++;
    if (axis_finish !== 4'hf || axis_start !== 4'hf || move_done !== 1'b0) begin
      errors++; $display("FAIL stag_allfin got fin %h start %h done %b", axis_finish, axis_start, move_done);
    end
    tick();
    checks++;
    if (move_done !== 1'b1 || axis_start !== 4'h0) begin
      errors++; $display("FAIL stag_gap got done %b start %h exp 1 0", move_done, axis_start);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_run();
    gen_en = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hC00 + i*16);
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (level !== 4'd3 || axis_start !== 4'hf) begin
      errors++; $display("FAIL rmid_pre got %0d start %h exp 3 f", level, axis_start);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (axis_start !== 4'h0 || level !== 4'd0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async got start %h lvl %0d rdy %b", axis_start, level, cmd_ready);
    end
    checks++;
    if (busy !== 1'b0 || moves_completed !== 32'd0 || axis_params !== '0) begin
      errors++; $display("FAIL rmid_outs got busy %b cnt %0d", busy, moves_completed);
    end
    tick();
    reset = 1'b0;
    gen_en = 1'b1;
    tick();
  endtask

`ifdef MOVE_SEQ_ABORT_EN
  task automatic test_abort();
    logic [639:0] d;
    int n;
    do_reset();
    abort = 1'b1;
    push_one(mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hD00));
    abort = 1'b0;
    checks++;
    if (level !== 4'd1) begin
      errors++; $display("FAIL abort_idle got %0d exp 1", level);
    end
    gen_en = 1'b0;
    push_one(mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hD10));
    push_one(mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hD20));
    checks++;
    if (level !== 4'd2 || axis_start !== 4'hf) begin
      errors++; $display("FAIL abort_pre got %0d start %h exp 2 f", level, axis_start);
    end
    abort = 1'b1;
    push_one(mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hD30));
    abort = 1'b0;
    checks++;
    if (level !== 4'd0 || axis_start !== 4'h0 || move_done !== 1'b0) begin
      errors++; $display("FAIL abort_flush got %0d start %h done %b", level, axis_start, move_done);
    end
    checks++;
    if (moves_completed !== 32'd0) begin
      errors++; $display("FAIL abort_count got %0d exp 0", moves_completed);
    end
    gen_en = 1'b1;
    repeat (3) tick();
    d = mk_cmd(32'd2, 32'd2, 32'd2, 32'd2, 32'hE00);
    push_one(d);
    n = 0;
    while (!move_done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (moves_completed !== 32'd1 || axis_params !== d) begin
      errors++; $display("FAIL abort_resume got %0d exp 1", moves_completed);
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    gen_en    = 1'b1;
`ifdef MOVE_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    test_reset();
    test_single_move();
    test_back_to_back();
    test_full_queue();
    test_staggered();
    test_reset_mid_run();
`ifdef MOVE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
